// File: rtl/gol_ui_pkg.sv
// Shared constants, state encodings and BCD digit helpers for the button-driven
// BCD entry path (bcd_entry_ctrl and btn_debounce).
package gol_ui_pkg;

    localparam int NUM_BTNS   = 5;
    localparam int NUM_DIGITS = 4;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic {
        ST_EDIT   = 1'b0,
        ST_COMMIT = 1'b1
    } ctrl_state_t;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_COMMIT = 3'd1,
        ACT_UP     = 3'd2,
        ACT_DOWN   = 3'd3,
        ACT_LEFT   = 3'd4,
        ACT_RIGHT  = 3'd5
    } action_t;

    // Digits wrap on their own; an out-of-range nibble is pulled back into 0..9.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return ((d == 4'd0) || (d > BCD_MAX)) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-FF synchroniser, stable-level debounce counter and a
// one-cycle press strobe on the rising edge of the accepted level.
module btn_debounce
    import gol_ui_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            sync1_reg   <= btn_raw;
            sync2_reg   <= sync1_reg;
            level_d_reg <= level_reg;
            // Any cycle agreeing with the accepted level restarts the stability count.
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_reg   <= '0;
                level_reg <= sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign btn_level = level_reg;
    assign btn_press = level_reg & ~level_d_reg;

endmodule

// File: rtl/bcd_entry_ctrl.sv
// Five-button 4-digit BCD editor with cursor and commit register.
// Optional up/down auto-repeat is compiled in when AUTOREPEAT_EN is defined.
module bcd_entry_ctrl
    import gol_ui_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int          REPEAT_DELAY    = 50_000_000,
    parameter int          REPEAT_PERIOD   = 10_000_000,
    parameter logic [15:0] INIT_VALUE      = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_center,
    output logic [15:0] edit_value,
    output logic [1:0]  cursor,
    output logic [15:0] committed_value,
    output logic        commit_pulse,
    output logic        dirty
);

    logic [NUM_BTNS-1:0] btn_raw_vec;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] evt;

    assign btn_raw_vec = {btn_center, btn_right, btn_left, btn_down, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk      (clk),
                .reset    (reset),
                .btn_raw  (btn_raw_vec[gi]),
                .btn_level(btn_level[gi]),
                .btn_press(btn_press[gi])
            );
        end
    endgenerate

`ifdef AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    rpt_state_t       rpt_state_reg, rpt_state_next;
    logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
    logic             rpt_down_reg, rpt_down_next;
    logic             rpt_held;
    logic             rpt_due;
    logic             rpt_fire;
    logic             other_press;

    assign other_press = btn_press[BTN_CENTER] | btn_press[BTN_LEFT] | btn_press[BTN_RIGHT];
    assign rpt_held    = rpt_down_reg ? btn_level[BTN_DOWN] : btn_level[BTN_UP];
    assign rpt_due     = ((rpt_state_reg == RPT_HOLD)   && (rpt_cnt_reg == RPT_W'(REPEAT_DELAY - 1))) ||
                         ((rpt_state_reg == RPT_REPEAT) && (rpt_cnt_reg == RPT_W'(REPEAT_PERIOD - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_state_reg <= RPT_IDLE;
            rpt_cnt_reg   <= '0;
            rpt_down_reg  <= 1'b0;
        end else begin
            rpt_state_reg <= rpt_state_next;
            rpt_cnt_reg   <= rpt_cnt_next;
            rpt_down_reg  <= rpt_down_next;
        end
    end

    always_comb begin
        rpt_state_next = rpt_state_reg;
        rpt_cnt_next   = rpt_cnt_reg + 1'b1;
        rpt_down_next  = rpt_down_reg;
        if (other_press) begin
            rpt_state_next = RPT_IDLE;
            rpt_cnt_next   = '0;
        end else if (btn_press[BTN_UP]) begin
            rpt_state_next = RPT_HOLD;
            rpt_cnt_next   = '0;
            rpt_down_next  = 1'b0;
        end else if (btn_press[BTN_DOWN]) begin
            rpt_state_next = RPT_HOLD;
            rpt_cnt_next   = '0;
            rpt_down_next  = 1'b1;
        end else begin
            case (rpt_state_reg)
                RPT_HOLD, RPT_REPEAT: begin
                    if (!rpt_held) begin
                        rpt_state_next = RPT_IDLE;
                        rpt_cnt_next   = '0;
                    end else if (rpt_due) begin
                        rpt_state_next = RPT_REPEAT;
                        rpt_cnt_next   = '0;
                    end
                end
                default: begin
                    rpt_state_next = RPT_IDLE;
                    rpt_cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rpt_fire = rpt_held & rpt_due;
    end

    // Synthetic steps join the real presses and go through the same arbiter.
    always_comb begin
        evt           = btn_press;
        evt[BTN_UP]   = btn_press[BTN_UP]   | (rpt_fire & ~rpt_down_reg);
        evt[BTN_DOWN] = btn_press[BTN_DOWN] | (rpt_fire &  rpt_down_reg);
    end
`else
    localparam int unused_rpt_params = REPEAT_DELAY + REPEAT_PERIOD;
    logic unused_levels;
    assign unused_levels = ^btn_level;
    assign evt           = btn_press;
`endif

    action_t action;

    always_comb begin
        action = ACT_NONE;
        if (evt[BTN_CENTER])     action = ACT_COMMIT;
        else if (evt[BTN_UP])    action = ACT_UP;
        else if (evt[BTN_DOWN])  action = ACT_DOWN;
        else if (evt[BTN_LEFT])  action = ACT_LEFT;
        else if (evt[BTN_RIGHT]) action = ACT_RIGHT;
    end

    ctrl_state_t ctrl_state_reg, ctrl_state_next;

    always_ff @(posedge clk) begin
        if (reset) ctrl_state_reg <= ST_EDIT;
        else       ctrl_state_reg <= ctrl_state_next;
    end

    always_comb begin
        ctrl_state_next = (action == ACT_COMMIT) ? ST_COMMIT : ST_EDIT;
    end

    always_comb begin
        commit_pulse = (ctrl_state_reg == ST_COMMIT);
    end

    logic [15:0] edit_value_reg, edit_value_next;
    logic [15:0] committed_value_reg;
    logic [1:0]  cursor_reg, cursor_next;
    logic        dirty_reg;

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic sel;
            assign sel = (cursor_reg == 2'(gi));
            assign edit_value_next[gi*4 +: 4] =
                (sel && action == ACT_UP)   ? bcd_inc(edit_value_reg[gi*4 +: 4]) :
                (sel && action == ACT_DOWN) ? bcd_dec(edit_value_reg[gi*4 +: 4]) :
                                              edit_value_reg[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        cursor_next = cursor_reg;
        if (action == ACT_LEFT)       cursor_next = cursor_reg + 2'd1;
        else if (action == ACT_RIGHT) cursor_next = cursor_reg - 2'd1;
    end

    // committed_value loads on the edge into COMMIT so it is new while commit_pulse is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            edit_value_reg      <= INIT_VALUE;
            committed_value_reg <= INIT_VALUE;
            cursor_reg          <= 2'd0;
            dirty_reg           <= 1'b0;
        end else begin
            edit_value_reg <= edit_value_next;
            cursor_reg     <= cursor_next;
            dirty_reg      <= (edit_value_reg != committed_value_reg);
            if (action == ACT_COMMIT) committed_value_reg <= edit_value_reg;
        end
    end

    assign edit_value      = edit_value_reg;
    assign committed_value = committed_value_reg;
    assign cursor          = cursor_reg;
    assign dirty           = dirty_reg;

endmodule
